// File: rtl/alu_pipe.sv
// alu_pipe: WIDTH-bit handshaken ALU with {V,N,C,Z} flags and a result register that holds under backpressure.
// Define ALU_MUL_EN to add the iterative shift-add multiply (op 1000); otherwise op 1000 is reported as illegal.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_PSA = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1001;
`ifdef ALU_MUL_EN
  localparam logic [3:0]    OP_MUL   = 4'b1000;
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;
  logic [WIDTH+4:0] eval_s;
  logic             accept_s;
`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] step_s;
`endif

  // Single-cycle datapath: returns {err, flags, result}; anything not decoded here is illegal.
  function automatic logic [WIDTH+4:0] alu_eval(input logic [3:0] op_i,
                                                input logic [WIDTH-1:0] a_i,
                                                input logic [WIDTH-1:0] b_i);
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] r;
    logic [SHW-1:0]   sh;
    logic             c, v, e;
    logic [3:0]       f;
    wide = {(WIDTH+1){1'b0}};
    r    = {WIDTH{1'b0}};
    sh   = b_i[SHW-1:0];
    c    = 1'b0;
    v    = 1'b0;
    e    = 1'b0;
    case (op_i)
      OP_AND: r = a_i & b_i;
      OP_OR:  r = a_i | b_i;
      OP_XOR: r = a_i ^ b_i;
      OP_PSA: r = a_i;
      OP_ADD: begin
        wide = {1'b0, a_i} + {1'b0, b_i};
        r    = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        v    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (r[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        wide = {1'b0, a_i} - {1'b0, b_i};
        r    = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        v    = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (r[WIDTH-1] != a_i[WIDTH-1]);
      end
      // The extra guard bit catches the last bit shifted out (stays 0 for a zero shift).
      OP_SHL: begin
        wide = {1'b0, a_i} << sh;
        r    = wide[WIDTH-1:0];
        c    = wide[WIDTH];
      end
      OP_SHR: begin
        wide = {a_i, 1'b0} >> sh;
        r    = wide[WIDTH:1];
        c    = wide[0];
      end
      OP_SRA: begin
        wide = $signed({a_i, 1'b0}) >>> sh;
        r    = wide[WIDTH:1];
        c    = wide[0];
      end
      default: e = 1'b1;
    endcase
    if (e) begin
      f = 4'b0000;
      r = {WIDTH{1'b0}};
    end else begin
      f = {v, r[WIDTH-1], c, (r == {WIDTH{1'b0}})};
    end
    return {e, f, r};
  endfunction

  // Next-state and datapath: accept, hold under backpressure, and multiply iteration.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
    eval_s   = alu_eval(op, a, b);
    accept_s = in_valid && in_ready;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    step_s   = prod_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
`ifdef ALU_MUL_EN
          if (op == OP_MUL) begin
            state_d  = S_BUSY;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            prod_d   = {(2*WIDTH){1'b0}};
            cnt_d    = {CW{1'b0}};
          end else begin
            {err_d, flags_d, result_d} = eval_s;
            state_d = S_DONE;
          end
`else
          {err_d, flags_d, result_d} = eval_s;
          state_d = S_DONE;
`endif
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
`ifdef ALU_MUL_EN
      S_BUSY: begin
        prod_d   = step_s;
        mcand_d  = mcand_q << 1'b1;
        mplier_d = mplier_q >> 1'b1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = step_s[WIDTH-1:0];
          flags_d  = {1'b0, step_s[WIDTH-1], |step_s[2*WIDTH-1:WIDTH],
                      (step_s[WIDTH-1:0] == {WIDTH{1'b0}})};
          err_d    = 1'b0;
        end else begin
          state_d = S_BUSY;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      result_q <= {WIDTH{1'b0}};
      flags_q  <= 4'b0000;
      err_q    <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      prod_q   <= {(2*WIDTH){1'b0}};
      cnt_q    <= {CW{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign result = result_q;
  assign flags  = flags_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed test-plan checks plus a randomized handshake run against an integer reference model.
// Honours ALU_MUL_EN the same way the design does.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic [3:0] op = 4'd0;
  logic       in_ready, out_valid, err;
  logic [3:0] result, flags;

  int n_checks = 0;
  int n_errors = 0;

  alu_pipe #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: {err, V, N, C, Z, result[3:0]} from plain integer arithmetic, WIDTH=4.
  function automatic logic [8:0] ref_alu(input int o, input int x, input int y);
    int r, sx, sy, s, full;
    bit c, v, e;
    r = 0; c = 0; v = 0; e = 0; full = 0;
    sx = (x > 7) ? x - 16 : x;
    sy = (y > 7) ? y - 16 : y;
    s  = y % 4;
    case (o)
      0: r = x & y;
      1: r = x | y;
      4: r = x ^ y;
      7: r = x;
      2: begin full = sx + sy; v = (full > 7) || (full < -8); c = (x + y) > 15; r = (x + y) % 16; end
      3: begin full = sx - sy; v = (full > 7) || (full < -8); c = x < y; r = (x - y + 16) % 16; end
      5: begin r = (x << s) % 16; c = (s != 0) && (((x >> (4 - s)) & 1) == 1); end
      6: begin r = x >> s; c = (s != 0) && (((x >> (s - 1)) & 1) == 1); end
      9: begin r = (sx >>> s) & 15; c = (s != 0) && (((x >> (s - 1)) & 1) == 1); end
`ifdef ALU_MUL_EN
      8: begin full = x * y; r = full % 16; c = full > 15; end
`endif
      default: e = 1;
    endcase
    if (e) return 9'b1_0000_0000;
    else   return {1'b0, v, (r >= 8), c, (r == 0), r[3:0]};
  endfunction

  task automatic do_op(input string tag, input int o, input int x, input int y);
    logic [8:0] e;
    op = 4'(o); a = 4'(x); b = 4'(y); in_valid = 1'b1;
    #1 check({tag, "_ir"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = ref_alu(o, x, y);
    check({tag, "_ov"}, 32'(out_valid), 32'd1);
    check({tag, "_out"}, 32'({err, flags, result}), 32'(e));
  endtask

  int s_op[3] = '{2, 4, 9};
  int s_a[3]  = '{1, 12, 9};
  int s_b[3]  = '{2, 10, 1};

  logic [8:0] q[$];
  int         mul_left;
  bit         exp_ov, exp_ir;
  logic [8:0] bp_exp;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_res", 32'(result), 32'd0);
    check("rst_flg", 32'(flags), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ir", 32'(in_ready), 32'd1);

    do_op("add", 2, 7, 5);
    check("add_c", 32'({flags, result}), 32'({4'b1100, 4'd12}));
    do_op("sub", 3, 5, 7);
    check("sub_c", 32'({flags, result}), 32'({4'b0110, 4'd14}));
    do_op("shl", 5, 9, 1);
    check("shl_c", 32'({flags, result}), 32'({4'b0010, 4'd2}));
    do_op("and", 0, 5, 10);
    check("and_c", 32'({flags, result}), 32'({4'b0001, 4'd0}));

    // Multiply 7*5 = 35: low nibble 3, carry set.
    op = 4'd8; a = 4'd7; b = 4'd5; in_valid = 1'b1;
    #1 check("mul_ir", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef ALU_MUL_EN
    for (int i = 0; i < 4; i++) begin
      check("mul_busy_ov", 32'(out_valid), 32'd0);
      check("mul_busy_ir", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("mul_ov", 32'(out_valid), 32'd1);
    check("mul_out", 32'({err, flags, result}), 32'({1'b0, 4'b0010, 4'd3}));
`else
    check("mul_ov", 32'(out_valid), 32'd1);
    check("mul_out", 32'({err, flags, result}), 32'({1'b1, 4'b0000, 4'd0}));
`endif
    @(posedge clk); #1;

    // Backpressure: ADD result must hold while a new op waits at the input.
    out_ready = 1'b0;
    do_op("bp_add", 2, 3, 4);
    bp_exp = ref_alu(2, 3, 4);
    op = 4'(s_op[0]); a = 4'(s_a[0]); b = 4'(s_b[0]); in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_ov", 32'(out_valid), 32'd1);
      check("bp_hold", 32'({err, flags, result}), 32'(bp_exp));
      check("bp_ir", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      op = 4'(s_op[i]); a = 4'(s_a[i]); b = 4'(s_b[i]); in_valid = 1'b1; out_ready = 1'b1;
      #1 check("str_ir", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      check("str_ov", 32'(out_valid), 32'd1);
      check("str_out", 32'({err, flags, result}), 32'(ref_alu(s_op[i], s_a[i], s_b[i])));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("str_nodup", 32'(out_valid), 32'd0);

    do_op("ill", 15, 3, 3);
    check("ill_c", 32'({err, flags, result}), 32'({1'b1, 4'b0000, 4'd0}));
    @(posedge clk); #1;
    check("ill_once", 32'(out_valid), 32'd0);
    do_op("post_ill", 1, 3, 4);
    check("post_ill_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // Reset on the second BUSY cycle of a multiply.
    op = 4'd8; a = 4'd7; b = 4'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("mrst_ov", 32'(out_valid), 32'd0);
    check("mrst_res", 32'(result), 32'd0);
    check("mrst_ir", 32'(in_ready), 32'd1);
    rst = 1'b1;
    do_op("mrst_add", 2, 2, 3);

    // Randomized traffic against a queue-based model of the handshake.
    mul_left = 0;
    repeat (600) begin
      @(posedge clk); #1;
      exp_ov = (q.size() > 0) && (mul_left == 0);
      check("rnd_ov", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) check("rnd_out", 32'({err, flags, result}), 32'(q[0]));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op = 4'($urandom_range(0, 15));
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      #1;
      exp_ir = (mul_left == 0) && (!exp_ov || out_ready);
      check("rnd_ir", 32'(in_ready), 32'(exp_ir));
      if (exp_ov && out_ready) void'(q.pop_front());
      if (mul_left > 0) mul_left--;
      if (in_valid && exp_ir) begin
        q.push_back(ref_alu(int'(op), int'(a), int'(b)));
`ifdef ALU_MUL_EN
        if (op == 4'd8) mul_left = 4;
`endif
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised successor to the team's registered 4-bit ALU: WIDTH-bit operands, 4-bit opcode, status flags, valid/ready handshake on input and output.
- Single-cycle ops complete with 1-cycle latency. Optional iterative shift-add multiply runs for WIDTH cycles.
- Sits between the operand sequencer and the writeback stage. The result register holds its value under backpressure.

Parameters:
- WIDTH, 8, operand/result width in bits, >=2.
- SHW, $clog2(WIDTH), shift-amount field width taken from b[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- in_valid  input  1  operand/op valid
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B / shift amount
- op  input  4  opcode
- out_valid  output  1  result/flags valid
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  registered result
- flags  output  4  {V,N,C,Z}, registered with result
- err  output  1  illegal opcode for the held result

Behaviour:
- Reset (rst==0 at clk edge):
  - state=IDLE; out_valid=0, result=0, flags=0, err=0.
  - Any multiply in progress is abandoned. in_ready=1 from the first cycle after reset is released.
- States:
  - IDLE: no result held.
  - BUSY: multiply iterating.
  - DONE: result held.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational; never depends on in_valid.
- Accept = in_valid && in_ready. On accept, a/b/op are captured.
  - Single-cycle op: result/flags/err load, state->DONE, out_valid=1 next cycle.
  - MUL: state->BUSY.
- DONE: result/flags/err are held stable while out_ready==0.
  - out_ready=1 with no accept: state->IDLE, out_valid=0.
  - out_ready=1 with accept in the same cycle: new result loads (back-to-back, 1 op/cycle).
- Opcodes:
  - 0000 AND; 0001 OR; 0100 XOR; 0111 PASS A.
  - 0010 ADD: a+b.
  - 0011 SUB: a-b.
  - 0101 SHL: logical, by b[SHW-1:0].
  - 0110 SHR: logical.
  - 1001 SRA: arithmetic right.
  - 1000 MUL (see Optional Feature).
  - All others illegal: result=0, flags=0, err=1, still 1-cycle and handshaken.
- Flags:
  - Z = (result==0); N = result[WIDTH-1].
  - ADD: C=carry-out; V=signed overflow.
  - SUB: C=borrow (1 when a<b unsigned); V=signed overflow.
  - Shifts: C=last bit shifted out, 0 when shift amount=0; V=0.
  - Logic/PASS: C=0, V=0.
  - Shift amount >= WIDTH cannot occur, since SHW bits only.
- Width rules: all results truncated to WIDTH bits. No X on outputs after reset.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: op 1000 = unsigned a*b via shift-add.
  - BUSY for exactly WIDTH cycles, in_ready=0 throughout, then DONE.
  - out_valid asserts WIDTH+1 cycles after accept.
  - result = product[WIDTH-1:0]; C=1 if product[2*WIDTH-1:WIDTH]!=0; V=0; Z/N from result.
- Undefined: no BUSY state logic; op 1000 treated as illegal (result=0, err=1, 1-cycle).

Test Plan:
- WIDTH=4, ALU_MUL_EN defined, after reset with rst=0 for 2 cycles:
  - Check out_valid=0, result=0, flags=0, in_ready=1.
  - Then a=7, b=5, op=ADD -> next cycle out_valid=1, result=12, flags V=1 N=1 C=0 Z=0.
- a=5, b=7, op=SUB -> result=14, C=1, N=1, V=0, Z=0. Then op=SHL, b=1, a=1001 -> result=0010, C=1. Then op=AND, a=5, b=10 -> result=0, Z=1.
- a=7, b=5, op=MUL accept -> in_ready=0 for 4 cycles, out_valid on 5th cycle, result=3, C=1. Without ALU_MUL_EN -> 1-cycle, result=0, err=1.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD -> result/flags stable, in_ready=0. Then stream 3 ops with in_valid=out_ready=1 -> one result per cycle, no drops or duplicates.
- Reset mid-MUL: assert rst=0 on the 2nd BUSY cycle -> next cycle out_valid=0, result=0, in_ready=1. The next ADD completes normally.
- op=1111 -> result=0, flags=0, err=1, out_valid for one handshake. The following legal op clears err.
